sr_cell_updown_counter: RTL
===========================

# sr_cell_updown_counter

Synchronous up/down counter whose state bits are SR flip-flop cells driven with T-style excitation. It is the T-from-SR counterpart of the team's SR-from-T conversion: each bit is commanded to "toggle" or "hold", and that command is translated into S/R pairs per cell. The block adds load, enable, direction, a direct toggle-mask mode and terminal/wrap flags. It is used in the flip-flop conversion series as a reusable counter and excitation-logic exemplar.

## Interface
Parameters:
- WIDTH, default 4: counter width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; ignored while load=1.
- mode  input  1  0 = count mode, 1 = toggle-mask mode.
- up  input  1  count direction in count mode: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load of d; highest priority after reset.
- d  input  WIDTH  load value.
- t_in  input  WIDTH  per-bit toggle request, used only when mode=1.
- q  output  WIDTH  counter state; the SR cell outputs.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse on count-mode wrap-around.

## Operation
- Storage: WIDTH SR cells. Per edge, each cell holds when S=R=0, sets when S=1, and resets when R=1. S=R=1 never occurs by construction; asserting it is a design bug, and the bench checks for it.
- Per-bit toggle command T[i] is chosen by priority:
  - load=1: T is not used. S[i]=d[i] and R[i]=~d[i], so q is loaded to d regardless of en or mode.
  - en=0: S=R=0, so all bits hold.
  - mode=0 with up=1: T[0]=1, and T[i]=&q[i-1:0] for i>0.
  - mode=0 with up=0: T[0]=1, and T[i]=&~q[i-1:0] for i>0.
  - mode=1: T=t_in. The direction input up is ignored.
- SR excitation from T: S[i]=T[i]&~q[i] and R[i]=T[i]&q[i].
- Arithmetic: count mode is modulo 2^WIDTH. Increment wraps from all-ones to 0, and decrement wraps from 0 to all-ones.
- tc:
  - When mode=0: tc = (up & q==all-ones) | (~up & q==0).
  - When mode=1: tc=0.
- wrap: registered. It is 1 for exactly one cycle after an edge where load=0, en=1, mode=0 and tc=1 (the count actually wrapped). Otherwise it is 0.
- Toggle mode never produces wrap, even if q passes through 0 or all-ones.
- Simultaneous events:
  - load with en: load wins and wrap=0.
  - load with mode=1: load wins.
  - A change of up in the same cycle as en takes effect on that edge.

## Timing
- Reset: rst_n low clears q to 0 and wrap to 0 immediately, with no clock needed. tc then follows combinationally; it is 1 if up=0 and mode=0.
- Deassertion of rst_n is synchronous to the design. The first state change can occur at the first rising edge with rst_n high.
- Reset asserted mid-count aborts the count. No pending wrap pulse survives reset.
- Latency:
  - q updates one clock after load, en or t_in is sampled.
  - tc is zero-latency from q, up and mode.
  - wrap appears in the same cycle as the wrapped q value and lasts one cycle.
- There is no handshake. en is sampled on every edge, and holding en=1 gives one step per clock.

## Test plan
- Reset: drive rst_n low mid-count with q=4'h9 and no clock edge. Required: q=0 and wrap=0 immediately. With up=1 and mode=0, tc=0; with up=0, tc=1.
- Up-count wrap (WIDTH=4): load 4'hE, then en=1, up=1 for 3 edges. Required: q=F, then 0, then 1. tc=1 only while q=F. wrap=1 only in the cycle where q=0.
- Down-count wrap: load 4'h1, then en=1, up=0 for 3 edges. Required: q=0, then F, then E. tc=1 while q=0. wrap=1 in the cycle where q=F.
- Priority: with q=4'h3, assert load=1, d=4'hA, en=1, mode=1, t_in=4'hF. Required: q=A and wrap=0. On the next edge, with load=0, en=0 and t_in=4'hF, q stays A.
- Toggle mode: from q=4'h5, mode=1, en=1, t_in=4'hC. Required: q=9, then 5. wrap=0 and tc=0 throughout. Random t_in for 1000 cycles must match the model q_next = q ^ t_in.
- Excitation invariant: over 10k random cycles of load, en, mode, up, d and t_in, the bench asserts no cell ever has S&R=1. The bench also checks q against a reference model of the priority rules above.

Source files
------------

// File: rtl/sr_cell_updown_counter.sv
// Up/down counter built from SR storage cells with T-style excitation.
// Each bit gets a toggle/hold command, which is turned into an S/R pair per cell.
module sr_cell_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] t_in,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   all_ones;
  logic [WIDTH:0]   all_zeros;

  // Prefix chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
  // Bit 0 sees an empty prefix and therefore always toggles in count mode.
  assign all_ones[0]  = 1'b1;
  assign all_zeros[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign all_ones[i+1]  = all_ones[i] & q[i];
    assign all_zeros[i+1] = all_zeros[i] & ~q[i];
  end

  always_comb begin
    t = mode ? t_in : (up ? all_ones[WIDTH-1:0] : all_zeros[WIDTH-1:0]);
  end

  // NOTE: s and r get a default on every path so no latch is inferred.
  always_comb begin
    s = '0;
    r = '0;
    if (load) begin
      s = d;
      r = ~d;
    end else if (en) begin
      s = t & ~q;
      r = t & q;
    end
  end

  // Terminal count is the full prefix chain; toggle mode never reports it.
  assign tc = ~mode & (up ? all_ones[WIDTH] : all_zeros[WIDTH]);

  // One SR storage cell per bit: S sets, R resets, neither holds.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic cell_q;

    // NOTE: sequential state uses non-blocking assignments so every cell
    // samples the pre-edge q through the excitation logic.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cell_q <= 1'b0;
      end else if (s[i]) begin
        cell_q <= 1'b1;
      end else if (r[i]) begin
        cell_q <= 1'b0;
      end
    end

    assign q[i] = cell_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= ~load & en & ~mode & tc;
    end
  end

endmodule
